// File: rtl/sync_fifo_ctrl.sv
// rtl/sync_fifo_ctrl.sv - pointer/flag controller for a single-clock FIFO over a dual-port RAM
// Optional sticky overflow/underflow outputs are enabled by defining SYNC_FIFO_ERR_FLAGS_EN.
module sync_fifo_ctrl #(
  parameter int DEPTH    = 64,
  parameter int AF_LEVEL = 56,
  parameter int AE_LEVEL = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     wr_req,
  input  logic                     rd_req,
  output logic                     ram_wen,
  output logic                     ram_ren,
  output logic [$clog2(DEPTH)-1:0] ram_wr_addr,
  output logic [$clog2(DEPTH)-1:0] ram_rd_addr,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  ,
  output logic                     overflow,
  output logic                     underflow
`endif
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;

  localparam logic [PTR_W-1:0] ONE      = PTR_W'(1);
  localparam logic [PTR_W-1:0] FULL_CNT = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] AF_CNT   = PTR_W'(AF_LEVEL);
  localparam logic [PTR_W-1:0] AE_CNT   = PTR_W'(AE_LEVEL);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] count_q;
  logic             rd_valid_q;
  logic             push_ok;
  logic             pop_ok;

  // Flags come from the count register alone so no request input reaches them combinationally.
  assign full         = (count_q == FULL_CNT);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_CNT);
  assign almost_empty = (count_q <= AE_CNT);
  assign count        = count_q;
  assign rd_valid     = rd_valid_q;

  assign push_ok = wr_req & ~full  & ~clr & rst_n;
  assign pop_ok  = rd_req & ~empty & ~clr & rst_n;

  assign ram_wen     = push_ok;
  assign ram_ren     = pop_ok;
  assign ram_wr_addr = wr_ptr[ADDR_W-1:0];
  assign ram_rd_addr = rd_ptr[ADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + ONE;
      if (push_ok && !pop_ok)      count_q <= count_q + ONE;
      else if (pop_ok && !push_ok) count_q <= count_q - ONE;
      // Mirrors the RAM's one-cycle registered read.
      rd_valid_q <= pop_ok;
    end
  end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_req && full)  overflow  <= 1'b1;
      if (rd_req && empty) underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb/tb_sync_fifo_ctrl.sv - directed and random checks of sync_fifo_ctrl against a queue model
module tb_sync_fifo_ctrl;

  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 1;

  logic       clk = 1'b0;
  logic       rst_n, clr, wr_req, rd_req;
  logic       ram_wen, ram_ren, rd_valid, full, empty, almost_full, almost_empty;
  logic [2:0] ram_wr_addr, ram_rd_addr;
  logic [3:0] count;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic       overflow, underflow;
`endif

  int vectors     = 0;
  int miscompares = 0;

  // Model: queue of RAM addresses currently holding live entries, oldest first.
  int q[$];
  int wr_total;
  bit exp_rv, exp_ovf, exp_udf;

  always #5 clk = ~clk;

  sync_fifo_ctrl #(.DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_req(wr_req), .rd_req(rd_req),
    .ram_wen(ram_wen), .ram_ren(ram_ren), .ram_wr_addr(ram_wr_addr),
    .ram_rd_addr(ram_rd_addr), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    , .overflow(overflow), .underflow(underflow)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input bit w, input bit r, input bit c, input bit rn);
    int n;
    bit push, pop;
    wr_req = w; rd_req = r; clr = c; rst_n = rn;
    @(negedge clk);
    n    = q.size();
    push = w && rn && !c && (n != DEPTH);
    pop  = r && rn && !c && (n != 0);
    chk("ram_wen", ram_wen, push);
    chk("ram_ren", ram_ren, pop);
    chk("ram_wr_addr", ram_wr_addr, wr_total % DEPTH);
    chk("ram_rd_addr", ram_rd_addr, (n > 0) ? q[0] : wr_total % DEPTH);
    chk("count", count, n);
    chk("full", full, n == DEPTH);
    chk("empty", empty, n == 0);
    chk("almost_full", almost_full, n >= AF);
    chk("almost_empty", almost_empty, n <= AE);
    chk("rd_valid", rd_valid, exp_rv);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    chk("overflow", overflow, exp_ovf);
    chk("underflow", underflow, exp_udf);
`endif
    if (!rn || c) begin
      q.delete();
      wr_total = 0;
      exp_rv   = 0;
      exp_ovf  = 0;
      exp_udf  = 0;
    end else begin
      if (w && n == DEPTH) exp_ovf = 1;
      if (r && n == 0)     exp_udf = 1;
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back(wr_total % DEPTH);
        wr_total++;
      end
      exp_rv = pop;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    wr_total = 0; exp_rv = 0; exp_ovf = 0; exp_udf = 0;
    @(posedge clk);
    #1;
    cycle(0, 0, 0, 0);
    cycle(1, 1, 0, 0);
    // fill to full, then one rejected push
    repeat (8) cycle(1, 0, 0, 1);
    cycle(1, 0, 0, 1);
    cycle(0, 0, 0, 1);
    // drain to empty, then one rejected pop
    repeat (8) cycle(0, 1, 0, 1);
    cycle(0, 1, 0, 1);
    cycle(0, 0, 0, 1);
    // simultaneous push+pop at 0, 4 and 8
    cycle(1, 1, 0, 1);
    repeat (3) cycle(1, 0, 0, 1);
    cycle(1, 1, 0, 1);
    repeat (4) cycle(1, 0, 0, 1);
    cycle(1, 1, 0, 1);
    cycle(0, 0, 0, 1);
    // down to 3 entries, then interleaved pairs across the address wrap
    repeat (4) cycle(0, 1, 0, 1);
    repeat (20) cycle(1, 1, 0, 1);
    // up to 5, then flush with a concurrent push
    repeat (2) cycle(1, 0, 0, 1);
    cycle(1, 0, 1, 1);
    cycle(0, 0, 0, 1);
    // reset one cycle after a pop
    cycle(1, 0, 0, 1);
    cycle(0, 1, 0, 1);
    cycle(1, 1, 0, 0);
    cycle(0, 0, 0, 1);
    // random traffic with phased bias so both full and empty are visited
    for (int i = 0; i < 600; i++) begin
      bit w, r, c, rn;
      int bias;
      bias = ((i / 50) % 2 == 0) ? 75 : 25;
      w  = ($urandom_range(0, 99) < bias);
      r  = ($urandom_range(0, 99) < 100 - bias);
      c  = ($urandom_range(0, 39) == 0);
      rn = ($urandom_range(0, 79) != 0);
      cycle(w, r, c, rn);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
- Single-clock pointer/flag controller for a synchronous FIFO built on the team's dual-port RAM (both RAM clock pins tied to clk).
- Turns push/pop requests into RAM write/read enables and addresses, and tracks occupancy.
- Provides full, empty, almost-full, almost-empty, count, and a read-data-valid strobe aligned to the RAM's 1-cycle registered read.
- Data does not pass through this block; wr_data and rd_data connect directly to the RAM.

Parameters:
- DEPTH, 64, FIFO entries; power of 2, >= 4; must equal the RAM DEPTH.
- AF_LEVEL, 56, almost_full asserts when count >= AF_LEVEL; range 1..DEPTH.
- AE_LEVEL, 8, almost_empty asserts when count <= AE_LEVEL; range 0..DEPTH-1.

Ports:
- clk  input  1  single clock; drives the controller and both RAM clock inputs.
- rst_n  input  1  synchronous, active-low reset.
- clr  input  1  synchronous flush; takes priority over push/pop.
- wr_req  input  1  push request.
- rd_req  input  1  pop request.
- ram_wen  output  1  RAM write enable.
- ram_ren  output  1  RAM read enable.
- ram_wr_addr  output  $clog2(DEPTH)  RAM write address.
- ram_rd_addr  output  $clog2(DEPTH)  RAM read address.
- rd_valid  output  1  RAM rd_data is valid this cycle.
- full  output  1  FIFO holds DEPTH entries.
- empty  output  1  FIFO holds 0 entries.
- almost_full  output  1  count >= AF_LEVEL.
- almost_empty  output  1  count <= AE_LEVEL.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Decided: one clock (clk); reset rst_n is synchronous and active-low. All state updates on posedge clk only.
- State: wr_ptr and rd_ptr, each $clog2(DEPTH)+1 bits (extra wrap bit); count register; rd_valid register.
- Reset (rst_n=0 at a posedge):
  - wr_ptr=0, rd_ptr=0, count=0, rd_valid=0.
  - Outputs: empty=1, full=0, almost_empty=1 (AE_LEVEL>=0), almost_full=0.
  - ram_wen=0 and ram_ren=0 while rst_n=0.
- Accept rules (combinational from registered flags and the current requests):
  - push_ok = wr_req & ~full & ~clr & rst_n.
  - pop_ok = rd_req & ~empty & ~clr & rst_n.
  - ram_wen = push_ok; ram_ren = pop_ok.
  - ram_wr_addr = wr_ptr[ADDR_W-1:0]; ram_rd_addr = rd_ptr[ADDR_W-1:0].
- Pointer update:
  - push_ok: wr_ptr += 1.
  - pop_ok: rd_ptr += 1.
  - Both wrap naturally modulo 2*DEPTH.
- Count update:
  - +1 on push only; -1 on pop only.
  - Unchanged on both or neither.
  - Never exceeds DEPTH and never underflows.
- Flags:
  - Decoded combinationally from the count register only; no input-to-flag combinational path.
  - full = (count==DEPTH); empty = (count==0).
  - Must agree with pointer comparison: equal pointers means empty; MSBs differ with lower bits equal means full.
- Read latency:
  - rd_valid is ram_ren registered by one cycle.
  - The RAM drives rd_data in the same cycle as rd_valid=1.
- Simultaneous events:
  - Full + wr_req + rd_req: pop accepted, push rejected; count goes DEPTH -> DEPTH-1.
  - Empty + wr_req + rd_req: push accepted, pop rejected; count goes 0 -> 1.
  - Not full and not empty, both requested: both accepted, count unchanged.
  - Pushing while full is dropped silently; popping while empty is ignored.
- Flush (clr=1):
  - Next state equals reset state, except the optional error flags are also cleared.
  - Requests in that cycle are ignored; an rd_valid pending from the previous cycle still fires.
- Reset mid-stream: in-flight data is discarded, and rd_valid is forced to 0 on the reset edge.

Optional Feature:
- Macro: SYNC_FIFO_ERR_FLAGS_EN.
- When defined, two extra 1-bit outputs are added:
  - overflow: sticky; set on wr_req & full & ~clr.
  - underflow: sticky; set on rd_req & empty & ~clr.
  - Both are cleared only by rst_n=0 or clr=1.
  - Both are registered and assert the cycle after the offending request.
- When undefined, neither port exists and rejected requests leave no trace.

Test Plan:
- DEPTH=8, AF=6, AE=1. Reset, then 8 pushes with no pop:
  - ram_wr_addr goes 0..7.
  - count goes 1..8.
  - almost_full first asserts at count=6.
  - full=1 after the 8th push.
  - A 9th wr_req gives ram_wen=0, and overflow=1 when the macro is defined.
- From full, 8 pops:
  - ram_rd_addr goes 0..7.
  - rd_valid pulses one cycle after each ram_ren.
  - almost_empty asserts at count=1; empty=1 at count=0.
  - An extra rd_req gives ram_ren=0, and underflow=1 when the macro is defined.
- Simultaneous push+pop at count=0, count=4, and count=8: count becomes 1, 4, and 7 respectively.
- Wrap-around: 20 interleaved push/pop pairs at count=3. Addresses wrap 7 -> 0, ordering is preserved, and full and empty never assert.
- clr asserted at count=5 together with wr_req=1:
  - Next cycle count=0, empty=1, both pointers 0, ram_wen=0 in the clr cycle.
  - Error flags cleared.
- rst_n=0 one cycle after a pop:
  - rd_valid=0 on the reset edge.
  - All outputs at reset values.
  - ram_wen=ram_ren=0 while rst_n=0.
